// File: rtl/dequantizer_stream.sv
// Streaming Q5.10 -> Q15.16 dequantizer with a 2-entry output FIFO and
// per-frame delivered-word counter.
module dequantizer_stream #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] elem_count,
  output logic             frame_done
);

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } entry_t;

  // head_q is always the oldest entry so the outputs come straight from flops
  entry_t           head_q, head_d, tail_q, tail_d, wr_ent;
  logic [1:0]       occ_q, occ_d;
  logic             rdy_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             push, pop;

  always_comb begin
    wr_ent.data = {{10{in_data[15]}}, in_data, 6'b0};
    wr_ent.last = in_last;
  end

  assign in_ready   = rdy_q && (occ_q < 2'd2);
  assign out_valid  = (occ_q != 2'd0);
  assign out_data   = head_q.data;
  assign out_last   = head_q.last;
  assign elem_count = cnt_q;
  assign frame_done = done_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = wr_ent;
        else               tail_d = wr_ent;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      // push and pop together only happen at occupancy 1
      2'b11: head_d = wr_ent;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (pop) begin
      if (head_q.last) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
      rdy_q  <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      rdy_q  <= 1'b1;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_dequantizer_stream.sv
// Directed self-checking bench for dequantizer_stream (CNT_W=16 and CNT_W=4).
module tb_dequantizer_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic [15:0] in_data;
  logic        in_ready, out_valid, out_last, frame_done;
  logic [31:0] out_data;
  logic [15:0] elem_count;

  logic        in_valid4, in_last4, out_ready4;
  logic [15:0] in_data4;
  logic        in_ready4, out_valid4, out_last4, frame_done4;
  logic [31:0] out_data4;
  logic [3:0]  elem_count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dequantizer_stream #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .elem_count(elem_count), .frame_done(frame_done));

  dequantizer_stream #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .in_last(in_last4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_data(out_data4), .out_last(out_last4),
    .elem_count(elem_count4), .frame_done(frame_done4));

  function automatic logic [31:0] conv(input logic [15:0] d);
    return {{10{d[15]}}, d, 6'b0};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_last = 0; in_data = '0; out_ready = 0;
    in_valid4 = 0; in_last4 = 0; in_data4 = '0; out_ready4 = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_data, out_last, elem_count, frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b data=%h last=%b cnt=%0d done=%b, need all 0",
               in_ready, out_valid, out_data, out_last, elem_count, frame_done);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || in_ready4 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b/%b, need 1/1", in_ready, in_ready4);
    end
  endtask

  task automatic test_convert();
    logic [15:0] v [4];
    logic [31:0] e [4];
    v = '{16'h0400, 16'hFC00, 16'h7FFF, 16'h8000};
    e = '{32'h0001_0000, 32'hFFFF_0000, 32'h001F_FFC0, 32'hFFE0_0000};
    out_ready = 1;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== e[i-1]) begin
          errors++;
          $display("FAIL convert_%0d: got vld=%b data=%h, need vld=1 data=%h", i-1, out_valid, out_data, e[i-1]);
        end
      end
      if (i < 4) begin
        in_valid = 1; in_data = v[i]; in_last = (i == 3);
      end else begin
        in_valid = 0; in_last = 0;
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0 || elem_count !== 16'd0) begin
      errors++;
      $display("FAIL convert_drain: got vld=%b cnt=%0d, need vld=0 cnt=0", out_valid, elem_count);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    in_valid = 1; in_data = 16'h0001; in_last = 0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_data !== 32'h0000_0040) begin
      errors++;
      $display("FAIL bp_first: got rdy=%b data=%h, need rdy=1 data=00000040", in_ready, out_data);
    end
    in_data = 16'h0002;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_data !== 32'h0000_0040) begin
      errors++;
      $display("FAIL bp_full: got rdy=%b data=%h, need rdy=0 data=00000040", in_ready, out_data);
    end
    in_data = 16'h0003; in_last = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h0000_0040 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: got rdy=%b vld=%b data=%h last=%b, need 0 1 00000040 0",
               in_ready, out_valid, out_data, out_last);
    end
    out_ready = 1;
    @(negedge clk);
    checks++;
    if (out_data !== 32'h0000_0080 || in_ready !== 1'b1 || elem_count !== 16'd1) begin
      errors++;
      $display("FAIL bp_second: got data=%h rdy=%b cnt=%0d, need 00000080 1 1", out_data, in_ready, elem_count);
    end
    @(negedge clk);
    in_valid = 0; in_last = 0;
    checks++;
    if (out_data !== 32'h0000_00C0 || out_last !== 1'b1 || elem_count !== 16'd2) begin
      errors++;
      $display("FAIL bp_third: got data=%h last=%b cnt=%0d, need 000000c0 1 2", out_data, out_last, elem_count);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || elem_count !== 16'd0 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain: got vld=%b cnt=%0d done=%b, need 0 0 1", out_valid, elem_count, frame_done);
    end
    @(negedge clk);
  endtask

  task automatic test_frame();
    logic [15:0] ecnt;
    logic        edone;
    out_ready = 1;
    for (int c = 0; c <= 7; c++) begin
      if (c >= 1) begin
        ecnt  = (c - 1 < 5) ? 16'(c - 1) : 16'd0;
        edone = (c == 6);
        checks++;
        if (elem_count !== ecnt || frame_done !== edone) begin
          errors++;
          $display("FAIL frame_c%0d: got cnt=%0d done=%b, need cnt=%0d done=%b", c, elem_count, frame_done, ecnt, edone);
        end
      end
      in_valid = (c < 5); in_data = 16'(c * 16'h0100); in_last = (c == 4);
      @(negedge clk);
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic test_stream100();
    logic [15:0] w [100];
    int bad = 0;
    for (int i = 0; i < 100; i++) w[i] = 16'(i * 16'h0251 + 16'h8005);
    out_ready = 1;
    for (int c = 0; c <= 100; c++) begin
      if (c >= 1) begin
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== conv(w[c-1])) begin
          errors++; bad++;
          if (bad < 5)
            $display("FAIL stream_%0d: got rdy=%b vld=%b data=%h, need 1 1 %h",
                     c-1, in_ready, out_valid, out_data, conv(w[c-1]));
        end
      end
      if (c < 100) begin
        in_valid = 1; in_data = w[c]; in_last = (c == 99);
      end else begin
        in_valid = 0; in_last = 0;
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0 || elem_count !== 16'd0) begin
      errors++;
      $display("FAIL stream_end: got vld=%b cnt=%0d, need 0 0", out_valid, elem_count);
    end
  endtask

  task automatic test_saturate();
    logic [3:0] ecnt;
    out_ready4 = 1;
    for (int c = 0; c <= 21; c++) begin
      if (c >= 1) begin
        ecnt = (c - 1 >= 20) ? 4'd0 : (c - 1 > 15) ? 4'd15 : 4'(c - 1);
        checks++;
        if (elem_count4 !== ecnt || frame_done4 !== (c == 21)) begin
          errors++;
          $display("FAIL sat_c%0d: got cnt=%0d done=%b, need cnt=%0d done=%b", c, elem_count4, frame_done4, ecnt, (c == 21));
        end
      end
      in_valid4 = (c < 20); in_data4 = 16'(c); in_last4 = (c == 19);
      @(negedge clk);
    end
    in_valid4 = 0; in_last4 = 0;
  endtask

  task automatic test_midreset();
    out_ready = 0;
    in_valid = 1; in_data = 16'h1111; in_last = 0;
    @(negedge clk);
    in_data = 16'h2222;
    @(negedge clk);
    in_valid = 0;
    #1 rst = 1;
    #1;
    checks++;
    if ({in_ready, out_valid, out_data, out_last, elem_count, frame_done} !== '0) begin
      errors++;
      $display("FAIL midreset_async: got rdy=%b vld=%b data=%h last=%b cnt=%0d done=%b, need all 0",
               in_ready, out_valid, out_data, out_last, elem_count, frame_done);
    end
    out_ready = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    in_valid = 1; in_data = 16'h0C00; in_last = 1;
    @(negedge clk);
    in_valid = 0; in_last = 0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0003_0000 || out_last !== 1'b1 || elem_count !== 16'd0) begin
      errors++;
      $display("FAIL midreset_word: got vld=%b data=%h last=%b cnt=%0d, need 1 00030000 1 0",
               out_valid, out_data, out_last, elem_count);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1 || elem_count !== 16'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_done: got done=%b cnt=%0d vld=%b, need 1 0 0", frame_done, elem_count, out_valid);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_pulse: got done=%b, need 0", frame_done);
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_backpressure();
    test_frame();
    test_stream100();
    test_saturate();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
